// File: rtl/pcie_cfg_mgmt_pkg.sv
// rtl/pcie_cfg_mgmt_pkg.sv - shared encodings and widths for the cfg_mgmt arbiter
package pcie_cfg_mgmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } cfg_state_e;

  localparam int CFG_DATA_W = 32;
  localparam int CFG_BE_W   = 4;

  localparam logic [CFG_DATA_W-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // A single-port build still needs a 1-bit index/pointer.
  function automatic int ptr_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/pcie_cfg_mgmt_rr_pick.sv
// rtl/pcie_cfg_mgmt_rr_pick.sv - combinational round-robin select starting at ptr
module pcie_cfg_mgmt_rr_pick
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IW    = ptr_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    index,
  output logic [PORTS-1:0] onehot
);

  logic [2*PORTS-1:0] dbl;
  logic [2*PORTS-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    // Lower copy keeps only bits at/above ptr; the upper copy supplies the wrap.
    for (int i = 0; i < 2*PORTS; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    valid = |req;
    index = '0;
    for (int i = 2*PORTS-1; i >= 0; i--) begin
      if (masked[i]) index = IW'(i % PORTS);
    end
    onehot = valid ? (PORTS'(1) << index) : '0;
  end

endmodule

// File: rtl/pcie_cfg_mgmt_arbiter.sv
// rtl/pcie_cfg_mgmt_arbiter.sv - round-robin sharing of the PCIe core cfg_mgmt port with timeout
module pcie_cfg_mgmt_arbiter
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int FUNC_WIDTH = 8,
  parameter int TIMEOUT    = 1024,
  localparam int IW        = ptr_width(PORTS),
  localparam int CW        = $clog2(TIMEOUT+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]      s_cfg_mgmt_addr,
  input  logic [PORTS*FUNC_WIDTH-1:0]      s_cfg_mgmt_function_number,
  input  logic [PORTS-1:0]                 s_cfg_mgmt_write,
  input  logic [PORTS*CFG_DATA_W-1:0]      s_cfg_mgmt_write_data,
  input  logic [PORTS*CFG_BE_W-1:0]        s_cfg_mgmt_byte_enable,
  input  logic [PORTS-1:0]                 s_cfg_mgmt_read,
  output logic [CFG_DATA_W-1:0]            s_cfg_mgmt_read_data,
  output logic [PORTS-1:0]                 s_cfg_mgmt_read_write_done,
  output logic [PORTS-1:0]                 s_cfg_mgmt_error,
  output logic [ADDR_WIDTH-1:0]            m_cfg_mgmt_addr,
  output logic [FUNC_WIDTH-1:0]            m_cfg_mgmt_function_number,
  output logic [CFG_DATA_W-1:0]            m_cfg_mgmt_write_data,
  output logic [CFG_BE_W-1:0]              m_cfg_mgmt_byte_enable,
  output logic                             m_cfg_mgmt_write,
  output logic                             m_cfg_mgmt_read,
  input  logic [CFG_DATA_W-1:0]            m_cfg_mgmt_read_data,
  input  logic                             m_cfg_mgmt_read_write_done,
  output logic                             grant_active,
  output logic [IW-1:0]                    grant_index
);

  cfg_state_e state, state_n;
  logic [IW-1:0]          rr_ptr, rr_ptr_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          grant_n;
  logic                   active_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic [FUNC_WIDTH-1:0]  func_n;
  logic [CFG_DATA_W-1:0]  wdata_n;
  logic [CFG_BE_W-1:0]    be_n;
  logic                   wr_n, rd_n;
  logic [CFG_DATA_W-1:0]  rdata_n;
  logic [PORTS-1:0]       done_n, err_n;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [PORTS-1:0]       pick_onehot;
  logic [PORTS-1:0]       grant_onehot;

  pcie_cfg_mgmt_rr_pick #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_pick (
    .req    (s_cfg_mgmt_write | s_cfg_mgmt_read),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx),
    .onehot (pick_onehot)
  );

  assign grant_onehot = PORTS'(1) << grant_index;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    cnt_n    = cnt;
    grant_n  = grant_index;
    active_n = grant_active;
    addr_n   = m_cfg_mgmt_addr;
    func_n   = m_cfg_mgmt_function_number;
    wdata_n  = m_cfg_mgmt_write_data;
    be_n     = m_cfg_mgmt_byte_enable;
    wr_n     = m_cfg_mgmt_write;
    rd_n     = m_cfg_mgmt_read;
    rdata_n  = s_cfg_mgmt_read_data;
    done_n   = '0;
    err_n    = '0;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n  = ST_ISSUE;
          grant_n  = pick_idx;
          active_n = 1'b1;
          cnt_n    = '0;
          addr_n   = s_cfg_mgmt_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          func_n   = s_cfg_mgmt_function_number[pick_idx*FUNC_WIDTH +: FUNC_WIDTH];
          wdata_n  = s_cfg_mgmt_write_data[pick_idx*CFG_DATA_W +: CFG_DATA_W];
          be_n     = s_cfg_mgmt_byte_enable[pick_idx*CFG_BE_W +: CFG_BE_W];
          // Write wins when a port raises both strobes.
          wr_n     = |(pick_onehot & s_cfg_mgmt_write);
          rd_n     = ~(|(pick_onehot & s_cfg_mgmt_write));
          rr_ptr_n = (pick_idx == IW'(PORTS-1)) ? '0 : IW'(pick_idx + 1'b1);
        end
      end
      ST_ISSUE: begin
        if (m_cfg_mgmt_read_write_done) begin
          state_n  = ST_DONE;
          active_n = 1'b0;
          wr_n     = 1'b0;
          rd_n     = 1'b0;
          rdata_n  = m_cfg_mgmt_write ? '0 : m_cfg_mgmt_read_data;
          done_n   = grant_onehot;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          state_n  = ST_DONE;
          active_n = 1'b0;
          wr_n     = 1'b0;
          rd_n     = 1'b0;
          rdata_n  = TIMEOUT_RDATA;
          done_n   = grant_onehot;
          err_n    = grant_onehot;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr                     <= '0;
      cnt                        <= '0;
      grant_index                <= '0;
      grant_active               <= 1'b0;
      m_cfg_mgmt_addr            <= '0;
      m_cfg_mgmt_function_number <= '0;
      m_cfg_mgmt_write_data      <= '0;
      m_cfg_mgmt_byte_enable     <= '0;
      m_cfg_mgmt_write           <= 1'b0;
      m_cfg_mgmt_read            <= 1'b0;
      s_cfg_mgmt_read_data       <= '0;
      s_cfg_mgmt_read_write_done <= '0;
      s_cfg_mgmt_error           <= '0;
    end else begin
      rr_ptr                     <= rr_ptr_n;
      cnt                        <= cnt_n;
      grant_index                <= grant_n;
      grant_active               <= active_n;
      m_cfg_mgmt_addr            <= addr_n;
      m_cfg_mgmt_function_number <= func_n;
      m_cfg_mgmt_write_data      <= wdata_n;
      m_cfg_mgmt_byte_enable     <= be_n;
      m_cfg_mgmt_write           <= wr_n;
      m_cfg_mgmt_read            <= rd_n;
      s_cfg_mgmt_read_data       <= rdata_n;
      s_cfg_mgmt_read_write_done <= done_n;
      s_cfg_mgmt_error           <= err_n;
    end
  end

endmodule

// File: tb/tb_pcie_cfg_mgmt_arbiter.sv
// tb/tb_pcie_cfg_mgmt_arbiter.sv - directed vector bench for pcie_cfg_mgmt_arbiter
module tb_pcie_cfg_mgmt_arbiter;

  localparam int P  = 4;
  localparam int AW = 10;
  localparam int FW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [P*AW-1:0] s_addr;
  logic [P*FW-1:0] s_func;
  logic [P-1:0]    s_wr, s_rd;
  logic [P*32-1:0] s_wd;
  logic [P*4-1:0]  s_be;
  logic [31:0]     s_rdata;
  logic [P-1:0]    s_done, s_err;
  logic [AW-1:0]   m_addr;
  logic [FW-1:0]   m_func;
  logic [31:0]     m_wd;
  logic [3:0]      m_be;
  logic            m_wr, m_rd;
  logic [31:0]     m_rdata;
  logic            m_done;
  logic            grant_active;
  logic [1:0]      grant_index;

  int errors = 0;
  int checks = 0;

  pcie_cfg_mgmt_arbiter #(
    .PORTS(P), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW), .TIMEOUT(TO)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_cfg_mgmt_addr            (s_addr),
    .s_cfg_mgmt_function_number (s_func),
    .s_cfg_mgmt_write           (s_wr),
    .s_cfg_mgmt_write_data      (s_wd),
    .s_cfg_mgmt_byte_enable     (s_be),
    .s_cfg_mgmt_read            (s_rd),
    .s_cfg_mgmt_read_data       (s_rdata),
    .s_cfg_mgmt_read_write_done (s_done),
    .s_cfg_mgmt_error           (s_err),
    .m_cfg_mgmt_addr            (m_addr),
    .m_cfg_mgmt_function_number (m_func),
    .m_cfg_mgmt_write_data      (m_wd),
    .m_cfg_mgmt_byte_enable     (m_be),
    .m_cfg_mgmt_write           (m_wr),
    .m_cfg_mgmt_read            (m_rd),
    .m_cfg_mgmt_read_data       (m_rdata),
    .m_cfg_mgmt_read_write_done (m_done),
    .grant_active               (grant_active),
    .grant_index                (grant_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          wr;
    bit          rd;
    logic [9:0]  addr;
    logic [7:0]  func;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          k;
    logic [31:0] core_rdata;
    bit          exp_wr;
    bit          exp_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ports();
    for (int p = 0; p < P; p++) begin
      s_wr[p] = 1'b0;
      s_rd[p] = 1'b0;
      s_addr[p*AW +: AW] = 10'h150 | 10'(p);
      s_func[p*FW +: FW] = 8'hE0 | 8'(p);
      s_wd[p*32 +: 32]   = 32'h7700_0000 | 32'(p);
      s_be[p*4 +: 4]     = 4'(p + 1);
    end
  endtask

  task automatic set_port(input int p, input bit wr, input bit rd, input logic [9:0] a,
                          input logic [7:0] f, input logic [31:0] d, input logic [3:0] b);
    s_addr[p*AW +: AW] = a;
    s_func[p*FW +: FW] = f;
    s_wd[p*32 +: 32]   = d;
    s_be[p*4 +: 4]     = b;
    s_wr[p] = wr;
    s_rd[p] = rd;
  endtask

  task automatic wait_strobe(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (m_wr || m_rd) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    int lat;
    int scnt;
    @(negedge clk);
    set_port(v.port, v.wr, v.rd, v.addr, v.func, v.wdata, v.be);
    wait_strobe(ok, lat);
    check({tag, "_strobe_seen"}, 32'(ok), 32'd1);
    check({tag, "_latency"}, lat, 1);
    check({tag, "_m_write"}, 32'(m_wr), 32'(v.exp_wr));
    check({tag, "_m_read"}, 32'(m_rd), 32'(v.exp_rd));
    check({tag, "_m_addr"}, 32'(m_addr), 32'(v.addr));
    check({tag, "_m_func"}, 32'(m_func), 32'(v.func));
    check({tag, "_m_wdata"}, m_wd, v.wdata);
    check({tag, "_m_be"}, 32'(m_be), 32'(v.be));
    check({tag, "_grant_active"}, 32'(grant_active), 32'd1);
    check({tag, "_grant_index"}, 32'(grant_index), v.port);
    scnt = 1;
    repeat (v.k) begin
      @(negedge clk);
      if (m_wr || m_rd) scnt++;
    end
    check({tag, "_m_addr_held"}, 32'(m_addr), 32'(v.addr));
    m_rdata = v.core_rdata;
    m_done  = 1'b1;
    @(negedge clk);
    m_done  = 1'b0;
    m_rdata = 32'h0BAD_0BAD;
    check({tag, "_strobe_cycles"}, scnt, v.k + 1);
    check({tag, "_strobe_dropped"}, 32'(m_wr | m_rd), 32'd0);
    check({tag, "_s_done"}, 32'(s_done), 32'(4'(1) << v.port));
    check({tag, "_s_error"}, 32'(s_err), 32'd0);
    check({tag, "_s_rdata"}, s_rdata, v.exp_rdata);
    s_wr[v.port] = 1'b0;
    s_rd[v.port] = 1'b0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(s_done), 32'd0);
    check({tag, "_idle_after"}, 32'(grant_active | m_wr | m_rd), 32'd0);
  endtask

  task automatic grant_step(input int exp_port, input string tag);
    bit ok;
    int lat;
    wait_strobe(ok, lat);
    check({tag, "_strobe_seen"}, 32'(ok), 32'd1);
    check({tag, "_grant_index"}, 32'(grant_index), exp_port);
    check({tag, "_m_addr"}, 32'(m_addr), 32'h10 + exp_port);
  endtask

  task automatic done_step(input int p, input string tag);
    m_rdata = 32'h1000 + p;
    m_done  = 1'b1;
    @(negedge clk);
    m_done  = 1'b0;
    check({tag, "_s_done"}, 32'(s_done), 32'(4'(1) << p));
    check({tag, "_s_rdata"}, s_rdata, 32'h1000 + p);
    s_wr[p] = 1'b0;
    s_rd[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_ports();
    m_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int cnt;
    int extra;

    vecs[0] = '{2, 1'b0, 1'b1, 10'h004, 8'h00, 32'h0000_0000, 4'h0, 3, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};
    vecs[1] = '{1, 1'b1, 1'b0, 10'h03F, 8'h01, 32'hA5A5_0000, 4'hC, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000};
    vecs[2] = '{3, 1'b1, 1'b1, 10'h2AA, 8'h03, 32'h0F0F_1234, 4'hF, 0, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0000_0000};
    vecs[3] = '{0, 1'b0, 1'b1, 10'h3FF, 8'hFF, 32'h1111_2222, 4'h3, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D};

    rst     = 1'b1;
    m_done  = 1'b0;
    m_rdata = 32'h0;
    clear_ports();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_write", 32'(m_wr), 32'd0);
    check("rst_m_read", 32'(m_rd), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_wdata", m_wd, 32'd0);
    check("rst_s_done", 32'(s_done), 32'd0);
    check("rst_s_error", 32'(s_err), 32'd0);
    check("rst_s_rdata", s_rdata, 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_index", 32'(grant_index), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout: core stays silent on a port 0 read.
    @(negedge clk);
    set_port(0, 1'b0, 1'b1, 10'h020, 8'h00, 32'h0, 4'hF);
    wait_strobe(ok, lat);
    check("to_strobe_seen", 32'(ok), 32'd1);
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_wr || m_rd) cnt++;
      else break;
    end
    check("to_strobe_cycles", cnt, TO);
    check("to_s_done", 32'(s_done), 32'h1);
    check("to_s_error", 32'(s_err), 32'h1);
    check("to_s_rdata", s_rdata, 32'hFFFF_FFFF);
    s_rd[0] = 1'b0;
    repeat (4) @(negedge clk);
    m_rdata = 32'h7777_7777;
    m_done  = 1'b1;
    extra   = 0;
    @(negedge clk);
    m_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (|s_done || |s_err || m_wr || m_rd) extra++;
      @(negedge clk);
    end
    check("to_late_done_ignored", extra, 0);

    // Contention from reset, then 0 and 3 re-request while 3 is served.
    do_reset();
    @(negedge clk);
    for (int p = 0; p < P; p++) set_port(p, 1'b0, 1'b1, 10'(32'h10 + p), 8'h00, 32'h0, 4'hF);
    for (int p = 0; p < 3; p++) begin
      grant_step(p, $sformatf("ct%0d", p));
      done_step(p, $sformatf("ct%0d", p));
    end
    grant_step(3, "ct3");
    set_port(0, 1'b0, 1'b1, 10'h010, 8'h00, 32'h0, 4'hF);
    done_step(3, "ct3");
    @(negedge clk);
    set_port(3, 1'b0, 1'b1, 10'h013, 8'h00, 32'h0, 4'hF);
    grant_step(0, "ct4");
    done_step(0, "ct4");
    grant_step(3, "ct5");
    done_step(3, "ct5");

    // Reset mid-ISSUE on a port 1 access, then check the pointer restarted at 0.
    repeat (2) @(negedge clk);
    set_port(1, 1'b0, 1'b1, 10'h011, 8'h00, 32'h0, 4'hF);
    wait_strobe(ok, lat);
    check("rs_grant_index", 32'(grant_index), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_strobe_async_drop", 32'(m_wr | m_rd), 32'd0);
    check("rs_grant_active", 32'(grant_active), 32'd0);
    @(negedge clk);
    clear_ports();
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (|s_done) extra++;
    end
    check("rs_no_done", extra, 0);
    set_port(0, 1'b0, 1'b1, 10'h010, 8'h00, 32'h0, 4'hF);
    set_port(2, 1'b0, 1'b1, 10'h012, 8'h00, 32'h0, 4'hF);
    grant_step(0, "rs0");
    done_step(0, "rs0");
    grant_step(2, "rs1");
    done_step(2, "rs1");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_cfg_mgmt_arbiter.md
# pcie_cfg_mgmt_arbiter

Round-robin arbiter that shares the single PCIe hard-core configuration management port (cfg_mgmt_*) between several internal requesters. Typical requesters are the host-facing register bridge, MSI-X table logic and a debug/ILA agent. The block sits between those clients and the UltraScale+ PCIe core in the pcie_user_clk domain. It serialises accesses with one transaction outstanding at a time, and it bounds every access with a timeout so that a hung core cannot stall a requester.

## Interface
- PORTS, 4: number of requesters, 1–16.
- ADDR_WIDTH, 10: cfg_mgmt DWORD address width.
- FUNC_WIDTH, 8: function number width.
- TIMEOUT, 1024: cycles allowed in ISSUE before abort, ≥4; counter width is $clog2(TIMEOUT+1).
- clk  in  1  pcie_user_clk.
- rst  in  1  asynchronous, active-high reset.
- s_cfg_mgmt_addr  in  PORTS*ADDR_WIDTH  per-port address, port i at slice i.
- s_cfg_mgmt_function_number  in  PORTS*FUNC_WIDTH  per-port function.
- s_cfg_mgmt_write  in  PORTS  per-port write request level.
- s_cfg_mgmt_write_data  in  PORTS*32  per-port write data.
- s_cfg_mgmt_byte_enable  in  PORTS*4  per-port byte enables.
- s_cfg_mgmt_read  in  PORTS  per-port read request level.
- s_cfg_mgmt_read_data  out  32  shared read data; valid only with a done pulse.
- s_cfg_mgmt_read_write_done  out  PORTS  one-hot completion pulse.
- s_cfg_mgmt_error  out  PORTS  timeout flag, coincident with the done pulse.
- m_cfg_mgmt_addr / function_number / write_data / byte_enable  out  ADDR_WIDTH / FUNC_WIDTH / 32 / 4  to the core.
- m_cfg_mgmt_write, m_cfg_mgmt_read  out  1  level strobes to the core.
- m_cfg_mgmt_read_data  in  32.
- m_cfg_mgmt_read_write_done  in  1.
- grant_active  out  1  high in ISSUE.
- grant_index  out  $clog2(PORTS)  port currently or last served.

## Operation
- Requester protocol:
  - Assert read or write with stable addr/function/data/be.
  - Hold until s_done[i] is seen.
  - Deassert in the cycle after s_done[i].
  - If read and write are both high on a port, write wins.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Request vector req = s_write | s_read.
  - If req≠0, the round-robin pick selects the first requesting port at or after rr_ptr, searching upward with wrap.
  - The selected port's fields are latched into the m_* registers, the strobe is raised, and the FSM goes to ISSUE.
  - rr_ptr is set to grant+1 mod PORTS.
- ISSUE:
  - The m_* outputs are held constant.
  - On m_done: capture m_read_data (writes capture 0), drop the strobe, go to DONE.
  - If the timeout counter reaches TIMEOUT-1 without m_done: drop the strobe, set the error flag, set read data to 32'hFFFF_FFFF, go to DONE.
- DONE:
  - s_done[grant]=1 and s_error[grant]=err for exactly one cycle, together with s_read_data.
  - Then go to IDLE.
  - No arbitration happens in DONE, so the granted port's stale request is never re-granted.
- An m_done that arrives outside ISSUE (a late completion after a timeout) is ignored.
- Requests arriving during ISSUE or DONE wait; fairness comes from rr_ptr, so no port waits more than PORTS grants.
- PORTS=1: rr_ptr is fixed at 0 and grant_index is 1 bit wide, tied to 0.

## Timing
- All outputs are registered.
- Reset values:
  - m_write=0, m_read=0, all m_* data/address fields=0.
  - s_done=0, s_error=0, s_read_data=0.
  - grant_active=0, grant_index=0.
  - rr_ptr=0 (port 0 highest priority), FSM=IDLE.
- Latency, with the request sampled in IDLE at cycle t:
  - m strobe high at t+1.
  - Core done at t+1+k, where k≥0 cycles are core latency.
  - s_done at t+2+k.
  - Next arbitration at t+3+k.
- Back-to-back accesses: the minimum period is 3 cycles plus core latency.
- Timeout: with no m_done, the strobe is high for exactly TIMEOUT cycles and s_done+s_error appear one cycle later.
- Reset asserted mid-ISSUE clears the strobes asynchronously. No done is emitted; requesters are reset by the same rst.
- A requester dropping its request during ISSUE is a protocol violation. The transaction still completes and the done pulse is still emitted.

## Structure
- Shared package/header (pcie_cfg_mgmt_pkg): FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DONE=2'd2), the timeout read-data constant 32'hFFFF_FFFF, and the cfg_mgmt field widths (DWORD data 32, byte enable 4).
- One sub-module, pcie_cfg_mgmt_rr_pick: combinational round-robin priority select.
  - Inputs: req[PORTS], ptr.
  - Outputs: valid, index, one-hot.
  - Implemented with a double-width mask/priority-encode.

## Test plan
- Single read: port 2 reads addr 10'h004, the core returns data 32'h1234_5678 after k=3 → m_read high for 4 cycles, s_done[2] pulses at t+5 with that data, and s_error=0.
- Contention: all 4 ports request simultaneously from reset → grants go in order 0,1,2,3. Then ports 0 and 3 re-request while 3 is active → next grants are 0, then 3.
- Write: port 1 writes 32'hA5A5_0000 with be=4'hC to addr 10'h3F → m_* fields match exactly, m_write is held until done, and s_done[1] is followed by IDLE.
- Timeout: with TIMEOUT=8 and the core silent → the strobe is high for 8 cycles, then s_done[0]=s_error[0]=1 with data 32'hFFFF_FFFF. A late m_done 5 cycles later is ignored and produces no extra pulse.
- Read and write both asserted on port 3 → a write is issued. Reset asserted mid-ISSUE → m_read/m_write drop in the same cycle, no s_done occurs, and rr_ptr returns to 0.
